// File: rtl/io_pkg.sv
// Shared definitions for core_io_slave: register map, STAT bit layout and AXI response codes.
package io_pkg;

  typedef enum logic [1:0] {
    RegRxData = 2'd0,
    RegTxData = 2'd1,
    RegStat   = 2'd2,
    RegCtrl   = 2'd3
  } io_reg_e;

  localparam int unsigned StatTxFull     = 0;
  localparam int unsigned StatRxNonEmpty = 1;
  localparam int unsigned StatRxFull     = 2;
  localparam int unsigned StatTxOvf      = 3;
  localparam int unsigned StatRxOvf      = 4;

  localparam int unsigned CtrlClrBit = 0;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/io_fifo.sv
// Byte FIFO with power-of-two depth; push and pop may coincide, including at full and at empty.
module io_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign rdata_o = mem_q[rptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/core_io_slave.sv
// AXI4-Lite slave bridging byte TX/RX streams through two FIFOs.
// Define IO_SLVERR_EN to report SLVERR on illegal accesses and dropped TX bytes.
module core_io_slave
  import io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [7:0]  TX_TDATA,
  output logic        TX_TVALID,
  input  logic        TX_TREADY,
  input  logic [7:0]  RX_TDATA,
  input  logic        RX_TVALID,
  output logic        RX_TREADY
);

  logic        awready_q, wready_q, aw_held_q, w_held_q;
  io_reg_e     awreg_q;
  logic [7:0]  wbyte_q;
  logic        wstb0_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q, bresp_d, rresp_d;
  logic [31:0] rdata_q, rdata_d, stat;
  logic        tx_ovf_q, rx_ovf_q, tx_ovf_d, rx_ovf_d;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_fire;
  io_reg_e     aw_reg_in, wr_reg, rd_reg;
  logic [7:0]  wr_byte, rx_head;
  logic        wr_stb0, wr_err, rd_err, ctrl_clr;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic        rx_pop, rx_full, rx_empty, rx_drop;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA[31:8], S_AXI_WSTB[3:1]};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ~rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign RX_TREADY     = 1'b1;
  assign TX_TVALID     = ~tx_empty;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign b_hs  = bvalid_q & S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID & ~rvalid_q;
  assign r_hs  = rvalid_q & S_AXI_RREADY;

  // Either half may come from this cycle's handshake or from the held copy.
  assign aw_reg_in = io_reg_e'(S_AXI_AWADDR[3:2]);
  assign wr_reg    = aw_held_q ? awreg_q : aw_reg_in;
  assign wr_byte   = w_held_q ? wbyte_q : S_AXI_WDATA[7:0];
  assign wr_stb0   = w_held_q ? wstb0_q : S_AXI_WSTB[0];
  assign wr_fire   = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

  assign tx_push  = wr_fire & (wr_reg == RegTxData) & wr_stb0;
  assign tx_pop   = TX_TVALID & TX_TREADY;
  assign tx_drop  = tx_push & tx_full & ~tx_pop;
  assign ctrl_clr = wr_fire & (wr_reg == RegCtrl) & wr_stb0 & wr_byte[CtrlClrBit];

  assign rd_reg  = io_reg_e'(S_AXI_ARADDR[3:2]);
  assign rx_pop  = ar_hs & (rd_reg == RegRxData) & ~rx_empty;
  assign rx_drop = RX_TVALID & rx_full & ~rx_pop;

  // An overflow in the clearing cycle wins over the clear.
  assign tx_ovf_d = (tx_ovf_q & ~ctrl_clr) | tx_drop;
  assign rx_ovf_d = (rx_ovf_q & ~ctrl_clr) | rx_drop;

`ifdef IO_SLVERR_EN
  assign wr_err = (wr_reg == RegRxData) | (wr_reg == RegStat) | tx_drop;
  assign rd_err = (rd_reg == RegTxData);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign bresp_d = wr_err ? RespSlverr : RespOkay;
  assign rresp_d = rd_err ? RespSlverr : RespOkay;

  always_comb begin
    stat                 = '0;
    stat[StatTxFull]     = tx_full;
    stat[StatRxNonEmpty] = ~rx_empty;
    stat[StatRxFull]     = rx_full;
    stat[StatTxOvf]      = tx_ovf_q;
    stat[StatRxOvf]      = rx_ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    unique case (rd_reg)
      RegRxData: rdata_d = rx_empty ? 32'h8000_0000 : {24'h0, rx_head};
      RegStat:   rdata_d = stat;
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awreg_q   <= RegRxData;
      wbyte_q   <= '0;
      wstb0_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awready_q <= 1'b0;
        awreg_q   <= aw_reg_in;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wready_q <= 1'b0;
        wbyte_q  <= S_AXI_WDATA[7:0];
        wstb0_q  <= S_AXI_WSTB[0];
      end
      // READY stays low after the write executes until the B beat completes.
      if (wr_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= bresp_d;
      end
      if (b_hs) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  io_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .push_i (tx_push),
    .wdata_i(wr_byte),
    .pop_i  (tx_pop),
    .rdata_o(TX_TDATA),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  io_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .push_i (RX_TVALID),
    .wdata_i(RX_TDATA),
    .pop_i  (rx_pop),
    .rdata_o(rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

endmodule

// File: tb/tb_core_io_slave.sv
// Directed self-checking bench for core_io_slave (FIFO_DEPTH = 16).
module tb_core_io_slave;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [7:0]  TX_TDATA;
  logic        TX_TVALID;
  logic        TX_TREADY;
  logic [7:0]  RX_TDATA;
  logic        RX_TVALID;
  logic        RX_TREADY;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int b_beats = 0;
  int last_b_cyc = 0;
  logic [7:0] tx_q[$];
  int tx_cyc_q[$];

  core_io_slave #(.FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTB(S_AXI_WSTB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .TX_TDATA(TX_TDATA), .TX_TVALID(TX_TVALID), .TX_TREADY(TX_TREADY),
    .RX_TDATA(RX_TDATA), .RX_TVALID(RX_TVALID), .RX_TREADY(RX_TREADY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Transfers complete on the following rising edge; inputs are stable at the falling edge.
  always @(negedge CLK) begin
    if (TX_TVALID && TX_TREADY) begin
      tx_q.push_back(TX_TDATA);
      tx_cyc_q.push_back(cyc);
    end
    if (S_AXI_BVALID && S_AXI_BREADY) b_beats++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTB = strb; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      tick();
      n++;
      if (aw_done) S_AXI_AWVALID = 1'b0;
      if (w_done) S_AXI_WVALID = 1'b0;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      tick();
      n++;
    end
    check("wr_bvalid_seen", {31'b0, S_AXI_BVALID}, 32'd1);
    last_b_cyc = cyc;
    resp = S_AXI_BRESP;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin
      tick();
      n++;
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin
      tick();
      n++;
    end
    check("rd_rvalid_seen", {31'b0, S_AXI_RVALID}, 32'd1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  exp_err;
    int bad;
    int b0;
    bit stable;

    RST_N = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0; TX_TREADY = 1'b0; RX_TDATA = '0; RX_TVALID = 1'b0;
`ifdef IO_SLVERR_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
`endif
    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    // Reset state
    check("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
    check("rst_wready", {31'b0, S_AXI_WREADY}, 32'd1);
    check("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd1);
    check("rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    check("rst_rvalid", {31'b0, S_AXI_RVALID}, 32'd0);
    check("rst_tx_tvalid", {31'b0, TX_TVALID}, 32'd0);
    check("rst_rx_tready", {31'b0, RX_TREADY}, 32'd1);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_bresp_rresp", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);

    // Single TX write drains straight out
    TX_TREADY = 1'b1;
    tx_q.delete(); tx_cyc_q.delete();
    do_write(4'h4, 32'h0000_0041, 4'h1, resp);
    check("tx_write_bresp", {30'b0, resp}, 32'd0);
    check("tx_beat_count", tx_q.size(), 32'd1);
    check("tx_beat_data", {24'b0, tx_q[0]}, 32'h41);
    check("tx_beat_latency", {31'b0, (tx_cyc_q[0] - last_b_cyc) <= 1}, 32'd1);
    check("tx_tvalid_idle", {31'b0, TX_TVALID}, 32'd0);

    // W three cycles ahead of AW, B held off for five cycles
    b0 = b_beats;
    S_AXI_WDATA = 32'h33; S_AXI_WSTB = 4'h1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    check("w_first_wready_low", {31'b0, S_AXI_WREADY}, 32'd0);
    check("w_first_awready_high", {31'b0, S_AXI_AWREADY}, 32'd1);
    tick(); tick();
    check("w_first_no_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    check("aw_late_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    check("aw_late_readies_low", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      if (!S_AXI_BVALID || S_AXI_BRESP !== 2'b00 || S_AXI_AWREADY || S_AXI_WREADY) stable = 0;
      tick();
    end
    check("b_held_stable", {31'b0, stable}, 32'd1);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("b_done_bvalid_low", {31'b0, S_AXI_BVALID}, 32'd0);
    check("b_done_readies_high", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    tick(); tick();
    check("b_single_beat", b_beats - b0, 32'd1);

    // TX overflow: 17 writes with the transmitter stalled
    TX_TREADY = 1'b0;
    tick(); tick();
    tx_q.delete(); tx_cyc_q.delete();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_write(4'h4, 32'h10 + i, 4'h1, resp);
      if (resp !== 2'b00) bad++;
    end
    check("tx_fill_bresp", bad, 32'd0);
    do_read(4'h8, rd, resp);
    check("stat_tx_full", rd, 32'h01);
    do_write(4'h4, 32'h20, 4'h1, resp);
    check("tx_ovf_bresp", {30'b0, resp}, {30'b0, exp_err});
    do_read(4'h8, rd, resp);
    check("stat_tx_ovf_full", rd, 32'h09);
    TX_TREADY = 1'b1;
    repeat (20) tick();
    check("tx_drain_count", tx_q.size(), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (tx_q[i] !== 8'(8'h10 + i)) bad++;
    check("tx_drain_order", bad, 32'd0);
    do_read(4'h8, rd, resp);
    check("stat_tx_ovf_sticky", rd, 32'h08);
    do_write(4'hC, 32'h1, 4'h1, resp);
    do_read(4'h8, rd, resp);
    check("stat_ctrl_clear", rd, 32'h00);

    // RX data path and illegal read
    do_read(4'h0, rd, resp);
    check("rx_empty_read", rd, 32'h8000_0000);
    check("rx_empty_rresp", {30'b0, resp}, 32'd0);
    RX_TDATA = 8'h5A; RX_TVALID = 1'b1;
    tick();
    RX_TVALID = 1'b0;
    do_read(4'h8, rd, resp);
    check("stat_rx_nonempty", rd, 32'h02);
    do_read(4'h0, rd, resp);
    check("rx_read_5a", rd, 32'h0000_005A);
    do_read(4'h8, rd, resp);
    check("stat_rx_drained", rd, 32'h00);
    do_read(4'h4, rd, resp);
    check("tx_data_read_value", rd, 32'h0);
    check("tx_data_read_rresp", {30'b0, resp}, {30'b0, exp_err});

    // RX full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      RX_TDATA = 8'(8'h80 + i); RX_TVALID = 1'b1;
      tick();
    end
    RX_TVALID = 1'b0;
    do_read(4'h8, rd, resp);
    check("stat_rx_full", rd, 32'h06);
    RX_TDATA = 8'hA5; RX_TVALID = 1'b1;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    RX_TVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("rx_push_pop_data", S_AXI_RDATA, 32'h80);
    tick();
    S_AXI_RREADY = 1'b0;
    do_read(4'h8, rd, resp);
    check("stat_rx_full_no_ovf", rd, 32'h06);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      do_read(4'h0, rd, resp);
      if (rd !== 32'h80 + i) bad++;
    end
    do_read(4'h0, rd, resp);
    if (rd !== 32'hA5) bad++;
    check("rx_order_after_push_pop", bad, 32'd0);
    do_read(4'h0, rd, resp);
    check("rx_empty_after_16", rd, 32'h8000_0000);

    // RX overflow, and an overflow in the clearing cycle keeps the flag
    for (int i = 0; i < 17; i++) begin
      RX_TDATA = 8'(i); RX_TVALID = 1'b1;
      tick();
    end
    RX_TVALID = 1'b0;
    do_read(4'h8, rd, resp);
    check("stat_rx_ovf", rd, 32'h16);
    fork
      do_write(4'hC, 32'h1, 4'h1, resp);
      begin
        RX_TDATA = 8'hEE; RX_TVALID = 1'b1;
        tick();
        RX_TVALID = 1'b0;
      end
    join
    do_read(4'h8, rd, resp);
    check("stat_clear_vs_ovf", rd, 32'h16);
    do_write(4'hC, 32'h1, 4'h1, resp);
    do_read(4'h8, rd, resp);
    check("stat_rx_ovf_cleared", rd, 32'h06);

    // Reset while a B beat is pending
    TX_TREADY = 1'b0;
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h77; S_AXI_WSTB = 4'h1; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b0;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("pre_rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    check("pre_rst_tx_tvalid", {31'b0, TX_TVALID}, 32'd1);
    RST_N = 1'b0;
    tick();
    check("rst_mid_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    check("rst_mid_readies", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
    check("rst_mid_tx_tvalid", {31'b0, TX_TVALID}, 32'd0);
    RST_N = 1'b1;
    b0 = b_beats;
    S_AXI_BREADY = 1'b1;
    repeat (5) tick();
    S_AXI_BREADY = 1'b0;
    check("rst_no_b_beat", b_beats - b0, 32'd0);
    do_read(4'h8, rd, resp);
    check("rst_stat_zero", rd, 32'h00);
    do_read(4'h0, rd, resp);
    check("rst_rx_empty", rd, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
